// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT in-place FFT stage sequencer: walks stages and butterflies, issues
// registered (top, bot, twiddle) commands over a valid/ready link, drains the pipe between stages.
module fft_stage_sequencer #(
    parameter int PIPE_LAT  = 4,
    parameter int ROM_DEPTH = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [3:0]                     n_log2,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           bf_valid,
    input  logic                           bf_ready,
    output logic [$clog2(ROM_DEPTH)-1:0]   bf_top,
    output logic [$clog2(ROM_DEPTH)-1:0]   bf_bot,
    output logic [$clog2(ROM_DEPTH)-1:0]   tw_addr,
    output logic [3:0]                     bf_stage,
    output logic                           bf_last
);

    localparam int AW = $clog2(ROM_DEPTH);
    localparam logic [AW-1:0] ONE        = AW'(1);
    localparam logic [3:0]    TW_SHIFT   = 4'(AW - 1);
    localparam logic [3:0]    MAX_LOG2   = 4'(AW);
    localparam logic [3:0]    DRAIN_INIT = 4'(PIPE_LAT);

    // Handshake: a command transfers on a rising edge where bf_valid and bf_ready are
    // both 1; while bf_valid=1 and bf_ready=0 every bf_* output holds its value.

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [3:0]    len_log2, len_log2_next;
    logic [3:0]    stage, stage_next;
    logic [AW-1:0] b, b_next;
    logic [3:0]    drain_cnt, drain_cnt_next;
    logic          busy_next, done_next, err_next, bf_valid_next, bf_last_next;
    logic [AW-1:0] bf_top_next, bf_bot_next, tw_addr_next;
    logic [3:0]    bf_stage_next;
    logic          load;
    logic [3:0]    cmd_stage;
    logic [AW-1:0] cmd_b;
    logic [AW-1:0] half_m1;

    function automatic logic [AW-1:0] calc_top(input logic [3:0] s, input logic [AW-1:0] bi);
        logic [AW-1:0] j;
        j = bi & ((ONE << s) - ONE);
        return ((bi >> s) << (s + 4'd1)) | j;
    endfunction

    function automatic logic [AW-1:0] calc_tw(input logic [3:0] s, input logic [AW-1:0] bi);
        logic [AW-1:0] j;
        j = bi & ((ONE << s) - ONE);
        return j << (TW_SHIFT - s);
    endfunction

    always_comb begin
        state_next     = state;
        len_log2_next  = len_log2;
        stage_next     = stage;
        b_next         = b;
        drain_cnt_next = drain_cnt;
        busy_next      = busy;
        done_next      = 1'b0;
        err_next       = 1'b0;
        bf_valid_next  = bf_valid;
        bf_top_next    = bf_top;
        bf_bot_next    = bf_bot;
        tw_addr_next   = tw_addr;
        bf_stage_next  = bf_stage;
        bf_last_next   = bf_last;
        load           = 1'b0;
        cmd_stage      = stage;
        cmd_b          = b;
        half_m1        = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (n_log2 != 4'd0 && n_log2 <= MAX_LOG2) begin
                        state_next    = ISSUE;
                        len_log2_next = n_log2;
                        stage_next    = 4'd0;
                        b_next        = '0;
                        busy_next     = 1'b1;
                        bf_valid_next = 1'b1;
                        load          = 1'b1;
                        cmd_stage     = 4'd0;
                        cmd_b         = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bf_ready) begin
                    if (bf_last) begin
                        state_next     = DRAIN;
                        bf_valid_next  = 1'b0;
                        drain_cnt_next = DRAIN_INIT;
                    end else begin
                        b_next    = b + ONE;
                        load      = 1'b1;
                        cmd_stage = stage;
                        cmd_b     = b + ONE;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    if (stage < len_log2 - 4'd1) begin
                        state_next    = ISSUE;
                        stage_next    = stage + 4'd1;
                        b_next        = '0;
                        bf_valid_next = 1'b1;
                        load          = 1'b1;
                        cmd_stage     = stage + 4'd1;
                        cmd_b         = '0;
                    end else begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    drain_cnt_next = drain_cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // The last butterfly of a stage is b == N/2-1, with N taken from the run being loaded.
        half_m1 = (ONE << (len_log2_next - 4'd1)) - ONE;
        if (load) begin
            bf_top_next   = calc_top(cmd_stage, cmd_b);
            bf_bot_next   = calc_top(cmd_stage, cmd_b) + (ONE << cmd_stage);
            tw_addr_next  = calc_tw(cmd_stage, cmd_b);
            bf_stage_next = cmd_stage;
            bf_last_next  = (cmd_b == half_m1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_log2  <= 4'd0;
            stage     <= 4'd0;
            b         <= '0;
            drain_cnt <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bf_valid  <= 1'b0;
            bf_top    <= '0;
            bf_bot    <= '0;
            tw_addr   <= '0;
            bf_stage  <= 4'd0;
            bf_last   <= 1'b0;
        end else begin
            state     <= state_next;
            len_log2  <= len_log2_next;
            stage     <= stage_next;
            b         <= b_next;
            drain_cnt <= drain_cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
            bf_valid  <= bf_valid_next;
            bf_top    <= bf_top_next;
            bf_bot    <= bf_bot_next;
            tw_addr   <= tw_addr_next;
            bf_stage  <= bf_stage_next;
            bf_last   <= bf_last_next;
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: command order, stall stability, drain timing,
// illegal/ignored starts and mid-run reset.
module tb_fft_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  n_log2;
    logic        busy, done, err, bf_valid, bf_ready, bf_last;
    logic [11:0] bf_top, bf_bot, tw_addr;
    logic [3:0]  bf_stage;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef logic [40:0] cmd_t;  // {stage, last, top, bot, tw}
    cmd_t exp_q[$];
    cmd_t got_q[$];

    fft_stage_sequencer #(.PIPE_LAT(4), .ROM_DEPTH(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_log2(n_log2),
        .busy(busy), .done(done), .err(err),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .bf_top(bf_top), .bf_bot(bf_bot), .tw_addr(tw_addr),
        .bf_stage(bf_stage), .bf_last(bf_last)
    );

    always #5 clk = ~clk;

    function automatic cmd_t pack(input logic [3:0] s, input logic l,
                                  input logic [11:0] t, input logic [11:0] bo, input logic [11:0] w);
        return {s, l, t, bo, w};
    endfunction

    // Hand-computed N=8 order.
    task automatic load_n8_table();
        int t[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int bo[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int w[12] = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};
        exp_q.delete();
        for (int i = 0; i < 12; i++)
            exp_q.push_back(pack(4'(i / 4), (i % 4) == 3, 12'(t[i]), 12'(bo[i]), 12'(w[i])));
    endtask

    // Textbook group/offset loop for larger transforms.
    task automatic build_expected(input int n);
        int nn, half;
        exp_q.delete();
        nn = 1 << n;
        for (int s = 0; s < n; s++) begin
            half = 1 << s;
            for (int g = 0; g < nn; g += 2 * half)
                for (int k = 0; k < half; k++)
                    exp_q.push_back(pack(4'(s), (g + 2 * half == nn) && (k == half - 1),
                                         12'(g + k), 12'(g + k + half), 12'(k * (4096 / (2 * half)))));
        end
    endtask

    task automatic run_transform(input logic [3:0] n, input bit stall, input int poke_at,
                                 input int budget, output int first_cyc, output int done_cyc,
                                 output int stall_bad, output int err_cnt, output bit timed_out);
        logic        held;
        logic        rdy;
        logic [40:0] h;
        got_q.delete();
        first_cyc = -1; done_cyc = -1; stall_bad = 0; err_cnt = 0; timed_out = 1'b1;
        held = 1'b0; h = '0;
        @(negedge clk);
        start = 1'b1; n_log2 = n; bf_ready = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start  = (i == poke_at) || (i == poke_at + 5);
            n_log2 = (i == poke_at) ? 4'd1 : ((i == poke_at + 5) ? 4'd0 : n);
            if (err) err_cnt++;
            if (held && (!bf_valid || pack(bf_stage, bf_last, bf_top, bf_bot, tw_addr) !== h))
                stall_bad++;
            if (done) begin
                done_cyc = i + 1; timed_out = 1'b0;
                break;
            end
            if (bf_valid && first_cyc < 0) first_cyc = i + 1;
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bf_ready = rdy;
            held = 1'b0;
            if (bf_valid && rdy) got_q.push_back(pack(bf_stage, bf_last, bf_top, bf_bot, tw_addr));
            else if (bf_valid) begin
                held = 1'b1;
                h = pack(bf_stage, bf_last, bf_top, bf_bot, tw_addr);
            end
        end
        start = 1'b0; bf_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; n_log2 = 4'd0; bf_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({busy, done, err, bf_valid, bf_last, bf_top, bf_bot, tw_addr, bf_stage} !== 45'd0) begin
            n_mismatched++;
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, err, bf_valid, bf_last, bf_top, bf_bot, tw_addr, bf_stage});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({busy, bf_valid, done, err} !== 4'b0) begin
            n_mismatched++;
            $display("FAIL reset_release_idle got=%b want=0000", {busy, bf_valid, done, err});
        end
    endtask

    task automatic test_single();
        int f, d, sb, ec; bit to;
        run_transform(4'd1, 1'b0, -100, 200, f, d, sb, ec, to);
        n_compared++;
        if (to !== 1'b0) begin n_mismatched++; $display("FAIL single_timeout got=%0d want=0", to); end
        n_compared++;
        if (got_q.size() !== 1) begin
            n_mismatched++; $display("FAIL single_count got=%0d want=1", got_q.size());
        end else begin
            n_compared++;
            if (got_q[0] !== pack(4'd0, 1'b1, 12'd0, 12'd1, 12'd0)) begin
                n_mismatched++; $display("FAIL single_cmd got=%h want=%h", got_q[0], pack(4'd0, 1'b1, 12'd0, 12'd1, 12'd0));
            end
        end
        n_compared++;
        if (d - f !== 6) begin n_mismatched++; $display("FAIL single_done_latency got=%0d want=6", d - f); end
    endtask

    task automatic test_n8();
        int f, d, sb, ec; bit to;
        load_n8_table();
        run_transform(4'd3, 1'b0, -100, 200, f, d, sb, ec, to);
        n_compared++;
        if (got_q.size() !== exp_q.size()) begin
            n_mismatched++; $display("FAIL n8_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_compared++;
            if (got_q[i] !== exp_q[i]) begin
                n_mismatched++; $display("FAIL n8_cmd[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        n_compared++;
        if (to !== 1'b0 || d - f !== 27) begin
            n_mismatched++; $display("FAIL n8_done_latency got=%0d want=27 (timeout=%0d)", d - f, to);
        end
    endtask

    // Start arriving in the DONE cycle, then an immediate second run.
    task automatic test_back_to_back();
        int f, d, sb, ec; bit to;
        load_n8_table();
        run_transform(4'd3, 1'b0, -100, 200, f, d, sb, ec, to);
        start = 1'b1; n_log2 = 4'd3;
        @(negedge clk);
        start = 1'b0;
        n_compared++;
        if ({busy, bf_valid, err} !== 3'b000) begin
            n_mismatched++; $display("FAIL done_cycle_start got=%b want=000", {busy, bf_valid, err});
        end
        @(negedge clk);
        n_compared++;
        if ({busy, bf_valid} !== 2'b00) begin
            n_mismatched++; $display("FAIL done_cycle_start_late got=%b want=00", {busy, bf_valid});
        end
        run_transform(4'd3, 1'b0, -100, 200, f, d, sb, ec, to);
        n_compared++;
        if (to !== 1'b0 || got_q.size() !== 12 || got_q[11] !== exp_q[11]) begin
            n_mismatched++; $display("FAIL back_to_back_run got_count=%0d want=12 timeout=%0d", got_q.size(), to);
        end
    endtask

    task automatic test_stall();
        int f, d, sb, ec; bit to;
        load_n8_table();
        run_transform(4'd3, 1'b1, -100, 500, f, d, sb, ec, to);
        n_compared++;
        if (to !== 1'b0) begin n_mismatched++; $display("FAIL stall_timeout got=%0d want=0", to); end
        n_compared++;
        if (got_q.size() !== exp_q.size()) begin
            n_mismatched++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_compared++;
            if (got_q[i] !== exp_q[i]) begin
                n_mismatched++; $display("FAIL stall_cmd[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        n_compared++;
        if (sb !== 0) begin n_mismatched++; $display("FAIL stall_hold_unstable got=%0d want=0", sb); end
    endtask

    task automatic test_illegal();
        logic [3:0] bad[3] = '{4'd0, 4'd13, 4'd15};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; n_log2 = bad[k];
            @(negedge clk);
            start = 1'b0;
            n_compared++;
            if ({err, busy, bf_valid} !== 3'b100) begin
                n_mismatched++; $display("FAIL illegal_err n=%0d got=%b want=100", bad[k], {err, busy, bf_valid});
            end
            @(negedge clk);
            n_compared++;
            if ({err, busy} !== 2'b00) begin
                n_mismatched++; $display("FAIL illegal_err_pulse n=%0d got=%b want=00", bad[k], {err, busy});
            end
        end
    endtask

    task automatic test_busy_start();
        int f, d, sb, ec; bit to;
        load_n8_table();
        run_transform(4'd3, 1'b0, 2, 200, f, d, sb, ec, to);
        n_compared++;
        if (ec !== 0) begin n_mismatched++; $display("FAIL busy_start_err got=%0d want=0", ec); end
        n_compared++;
        if (got_q.size() !== exp_q.size() || to !== 1'b0 || d - f !== 27) begin
            n_mismatched++;
            $display("FAIL busy_start_run got_count=%0d want=%0d latency=%0d want=27", got_q.size(), exp_q.size(), d - f);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_compared++;
            if (got_q[i] !== exp_q[i]) begin
                n_mismatched++; $display("FAIL busy_start_cmd[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_n4096();
        int f, d, sb, ec; bit to;
        build_expected(12);
        run_transform(4'd12, 1'b0, -100, 30000, f, d, sb, ec, to);
        n_compared++;
        if (to !== 1'b0 || got_q.size() !== 24576) begin
            n_mismatched++; $display("FAIL n4096_count got=%0d want=24576 timeout=%0d", got_q.size(), to);
        end
        if (got_q.size() > 0) begin
            n_compared++;
            if (got_q[got_q.size()-1] !== pack(4'd11, 1'b1, 12'd2047, 12'd4095, 12'd2047)) begin
                n_mismatched++; $display("FAIL n4096_final got=%h want=%h", got_q[got_q.size()-1],
                                         pack(4'd11, 1'b1, 12'd2047, 12'd4095, 12'd2047));
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_compared++;
            if (got_q[i] !== exp_q[i]) begin
                n_mismatched++; $display("FAIL n4096_cmd[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        n_compared++;
        if (d - f !== 12 * 2053) begin
            n_mismatched++; $display("FAIL n4096_done_latency got=%0d want=%0d", d - f, 12 * 2053);
        end
    endtask

    task automatic test_reset_mid_run();
        int f, d, sb, ec; bit to;
        bit found;
        int seen;
        found = 1'b0; seen = 0;
        @(negedge clk);
        start = 1'b1; n_log2 = 4'd3; bf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bf_valid && bf_stage == 4'd1 && bf_top == 12'd1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_compared++;
        if (!found) begin n_mismatched++; $display("FAIL midrun_reach_stage1 got=0 want=1"); end
        rst_n = 1'b0;
        #1;
        n_compared++;
        if ({busy, done, err, bf_valid, bf_last, bf_top, bf_bot, tw_addr, bf_stage} !== 45'd0) begin
            n_mismatched++;
            $display("FAIL midrun_reset_outputs got=%h want=0",
                     {busy, done, err, bf_valid, bf_last, bf_top, bf_bot, tw_addr, bf_stage});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy || bf_valid) seen++;
        end
        n_compared++;
        if (seen !== 0) begin n_mismatched++; $display("FAIL midrun_no_done got=%0d want=0", seen); end
        bf_ready = 1'b0;
        load_n8_table();
        run_transform(4'd3, 1'b0, -100, 200, f, d, sb, ec, to);
        n_compared++;
        if (got_q.size() !== exp_q.size() || to !== 1'b0 || d - f !== 27) begin
            n_mismatched++;
            $display("FAIL midrun_rerun got_count=%0d want=%0d latency=%0d want=27", got_q.size(), exp_q.size(), d - f);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_compared++;
            if (got_q[i] !== exp_q[i]) begin
                n_mismatched++; $display("FAIL midrun_rerun_cmd[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_n8();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_busy_start();
        test_reset_mid_run();
        test_n4096();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
